// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game state encodings, sprite geometry and hit defaults
package game_pkg;

  typedef enum logic [2:0] {
    GS_MENU  = 3'd0,
    GS_GAME  = 3'd1,
    GS_P1WIN = 3'd2,
    GS_P2WIN = 3'd3,
    GS_TIE   = 3'd4,
    GS_PIONT = 3'd5
  } game_state_e;

  typedef enum logic [1:0] {
    HR_IDLE   = 2'd0,
    HR_ALIVE  = 2'd1,
    HR_INVULN = 2'd2,
    HR_KO     = 2'd3
  } hr_state_e;

  // Sprite geometry in pixels; positions on the ports are in units of 10 px.
  localparam int ARMS_SIDE = 20;
  localparam int CH_WIDE   = 30;
  localparam int CH_HEIGHT = 50;

  localparam int HP_MAX_DEF       = 100;
  localparam int DAMAGE_DEF       = 10;
  localparam int INVULN_TICKS_DEF = 16;
  localparam int KNOCK_TICKS      = 4;

  localparam int POS_W = 7;
  localparam int PIX_W = 12;

  function automatic logic [PIX_W-1:0] to_px(input logic [POS_W-1:0] pos);
    return PIX_W'(pos) * PIX_W'(10);
  endfunction

endpackage

// File: rtl/hit_responder_if.sv
// rtl/hit_responder_if.sv - attacker projectile to defender hit handshake
interface hit_responder_if;
  import game_pkg::*;

  logic             arm_active;
  logic [POS_W-1:0] arm_x;
  logic [POS_W-1:0] arm_y;
  logic             hit_ack;

  modport master (output arm_active, arm_x, arm_y, input hit_ack);
  modport slave  (input arm_active, arm_x, arm_y, output hit_ack);

endinterface

// File: rtl/hit_box_cmp.sv
// rtl/hit_box_cmp.sv - combinational projectile vs. defender hit-box overlap test
module hit_box_cmp
  import game_pkg::*;
(
  input  logic [POS_W-1:0] arm_x_i,
  input  logic [POS_W-1:0] arm_y_i,
  input  logic [POS_W-1:0] loc_x_i,
  input  logic [POS_W-1:0] loc_y_i,
  output logic             hit_o
);

  logic [PIX_W-1:0] ax, ay, lx, ly;
  logic             x_ok, y_ok;

  always_comb begin
    ax = to_px(arm_x_i);
    ay = to_px(arm_y_i);
    lx = to_px(loc_x_i);
    ly = to_px(loc_y_i);
    // The lower-bound offset is added on the arm side so loc-20 is never formed.
    y_ok  = (ay + PIX_W'(ARMS_SIDE) >= ly) && (ay <= ly + PIX_W'(CH_HEIGHT - ARMS_SIDE));
    x_ok  = (ax + PIX_W'(ARMS_SIDE) >= lx) && (ax <= lx + PIX_W'(CH_WIDE - 1));
    hit_o = x_ok && y_ok;
  end

endmodule

// File: rtl/hit_responder.sv
// rtl/hit_responder.sv - defender HP / invulnerability / KO tracker
// Define HIT_KNOCKBACK_EN to drive knock for KNOCK_TICKS ticks after a non-fatal hit.
module hit_responder
  import game_pkg::*;
#(
  parameter int DAMAGE       = DAMAGE_DEF,
  parameter int INVULN_TICKS = INVULN_TICKS_DEF,
  parameter int HP_MAX       = HP_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [2:0]        state,
  hit_responder_if.slave    arm,
  input  logic [POS_W-1:0]  loc_x,
  input  logic [POS_W-1:0]  loc_y,
  output logic [7:0]        hp,
  output logic              flash,
  output logic              ko,
  output logic              knock
);

  localparam logic [7:0] HP_MAX_V = 8'(HP_MAX);
  localparam logic [7:0] DAMAGE_V = 8'(DAMAGE);
  localparam logic [7:0] INVULN_V = 8'(INVULN_TICKS);

  hr_state_e  fsm_q, fsm_d;
  logic [7:0] hp_q, hp_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ack_q, ack_d;

  logic       collide;
  logic       in_game;
  logic       hit_accept;
  logic [7:0] hp_after;

  hit_box_cmp u_hit_box (
    .arm_x_i (arm.arm_x),
    .arm_y_i (arm.arm_y),
    .loc_x_i (loc_x),
    .loc_y_i (loc_y),
    .hit_o   (collide)
  );

  always_comb begin
    in_game    = (state == GS_GAME);
    hit_accept = tick && in_game && (fsm_q == HR_ALIVE) && arm.arm_active && collide;
    hp_after   = (hp_q > DAMAGE_V) ? (hp_q - DAMAGE_V) : 8'd0;
  end

  always_comb begin
    fsm_d = fsm_q;
    hp_d  = hp_q;
    cnt_d = cnt_q;
    ack_d = 1'b0;
    if (tick) begin
      if (!in_game) begin
        fsm_d = HR_IDLE;
        hp_d  = HP_MAX_V;
        cnt_d = 8'd0;
      end else begin
        case (fsm_q)
          HR_IDLE: fsm_d = HR_ALIVE;
          HR_ALIVE: begin
            if (hit_accept) begin
              hp_d  = hp_after;
              ack_d = 1'b1;
              if (hp_after == 8'd0) begin
                fsm_d = HR_KO;
                cnt_d = 8'd0;
              end else begin
                fsm_d = HR_INVULN;
                cnt_d = INVULN_V;
              end
            end
          end
          HR_INVULN: begin
            // Projectile passes through; leave on the tick the count reaches zero.
            if (cnt_q <= 8'd1) begin
              cnt_d = 8'd0;
              fsm_d = HR_ALIVE;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
          HR_KO: fsm_d = HR_KO;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= HR_IDLE;
      hp_q  <= HP_MAX_V;
      cnt_q <= 8'd0;
      ack_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      hp_q  <= hp_d;
      cnt_q <= cnt_d;
      ack_q <= ack_d;
    end
  end

  assign hp          = hp_q;
  assign arm.hit_ack = ack_q;
  assign flash       = (fsm_q == HR_INVULN) && cnt_q[1];
  assign ko          = (fsm_q == HR_KO);

`ifdef HIT_KNOCKBACK_EN
  logic [2:0] knock_q, knock_d;

  always_comb begin
    knock_d = knock_q;
    if (tick) begin
      if (!in_game) begin
        knock_d = 3'd0;
      end else if (hit_accept && (hp_after != 8'd0)) begin
        knock_d = 3'(KNOCK_TICKS);
      end else if (knock_q != 3'd0) begin
        knock_d = knock_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      knock_q <= 3'd0;
    end else begin
      knock_q <= knock_d;
    end
  end

  assign knock = (knock_q != 3'd0);
`else
  assign knock = 1'b0;
`endif

endmodule

// File: tb/tb_hit_responder.sv
// tb/tb_hit_responder.sv - scoreboard bench for hit_responder against a tick-level game model
module tb_hit_responder;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [2:0] state;
  logic [6:0] loc_x, loc_y;
  logic [7:0] hp;
  logic       flash, ko, knock;

  hit_responder_if arm_if ();

  hit_responder dut (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .state (state),
    .arm   (arm_if),
    .loc_x (loc_x),
    .loc_y (loc_y),
    .hp    (hp),
    .flash (flash),
    .ko    (ko),
    .knock (knock)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hp;
    int ack;
    int flash;
    int ko;
    int knock;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Stimulus applied at the next negedge
  bit   rst_hold;
  int   st_cur;
  int   lx_cur, ly_cur;

  // Reference model: defender life expressed as plain counters
  bit   m_game;
  bit   m_ko;
  int   m_hp, m_inv, m_knock, m_ack;

  function automatic bit overlap(int ax, int ay, int lx, int ly);
    return (10*ay >= 10*ly - 20) && (10*ay <= 10*ly + 30) &&
           (10*ax >= 10*lx - 20) && (10*ax <= 10*lx + 29);
  endfunction

  task automatic cmp(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_update();
    exp_t e;
    m_ack = 0;
    if (rst) begin
      m_game = 0; m_ko = 0; m_hp = 100; m_inv = 0; m_knock = 0;
    end else if (tick) begin
      if (state != 3'd1) begin
        m_game = 0; m_ko = 0; m_hp = 100; m_inv = 0; m_knock = 0;
      end else if (!m_game) begin
        m_game = 1;
      end else begin
        if (m_knock > 0) m_knock--;
        if (!m_ko) begin
          if (m_inv > 0) begin
            m_inv--;
          end else if (arm_if.arm_active &&
                       overlap(int'(arm_if.arm_x), int'(arm_if.arm_y), int'(loc_x), int'(loc_y))) begin
            m_hp  = (m_hp > 10) ? m_hp - 10 : 0;
            m_ack = 1;
            if (m_hp == 0) begin
              m_ko = 1;
            end else begin
              m_inv   = 16;
              m_knock = 4;
            end
          end
        end
      end
    end
    e.hp    = m_hp;
    e.ack   = m_ack;
    e.flash = (m_inv > 0) ? ((m_inv >> 1) & 1) : 0;
    e.ko    = m_ko;
`ifdef HIT_KNOCKBACK_EN
    e.knock = (m_knock > 0);
`else
    e.knock = 0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic step(input bit t, input bit act, input int ax, input int ay);
    @(negedge clk);
    rst               = rst_hold;
    tick              = t;
    state             = 3'(st_cur);
    loc_x             = 7'(lx_cur);
    loc_y             = 7'(ly_cur);
    arm_if.arm_active = act;
    arm_if.arm_x      = 7'(ax);
    arm_if.arm_y      = 7'(ay);
    model_update();
  endtask

  task automatic tk(input bit act, input int ax, input int ay);
    step(1'b1, act, ax, ay);
    step(1'b0, act, ax, ay);
  endtask

  // Asynchronous reset must clear outputs before any clock edge.
  task automatic reset_now();
    @(negedge clk);
    rst_hold = 1'b1;
    rst      = 1'b1;
    tick     = 1'b0;
    #1;
    cmp("async_rst_hp", hp, 100);
    cmp("async_rst_ack", arm_if.hit_ack, 0);
    cmp("async_rst_flash", flash, 0);
    cmp("async_rst_ko", ko, 0);
    cmp("async_rst_knock", knock, 0);
    model_update();
  endtask

  // Monitor: every cycle the DUT presents a new output set, check it against the queue head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        cmp("hp", hp, e.hp);
        cmp("hit_ack", arm_if.hit_ack, e.ack);
        cmp("flash", flash, e.flash);
        cmp("ko", ko, e.ko);
        cmp("knock", knock, e.knock);
      end
    end
  end

  initial begin
    int r;
    int dx;
    rst = 1'b1; rst_hold = 1'b1; tick = 1'b0; state = 3'd0;
    loc_x = 7'd40; loc_y = 7'd30;
    arm_if.arm_active = 1'b0; arm_if.arm_x = 7'd0; arm_if.arm_y = 7'd0;
    st_cur = 0; lx_cur = 40; ly_cur = 30;
    m_game = 0; m_ko = 0; m_hp = 100; m_inv = 0; m_knock = 0; m_ack = 0;

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_hold = 1'b0;
    step(0, 0, 0, 0);

    st_cur = 1;
    tk(0, 0, 0);
    tk(1, 39, 30);
    repeat (16) tk(1, 39, 30);
    tk(1, 39, 30);

    repeat (16) tk(0, 0, 0);
    tk(1, 43, 30);
    tk(1, 38, 30);
    repeat (16) tk(0, 0, 0);
    tk(1, 37, 30);
    tk(1, 40, 33);
    tk(1, 40, 27);
    repeat (16) tk(0, 0, 0);

    repeat (6) begin
      tk(1, 40, 30);
      repeat (16) tk(0, 0, 0);
    end
    tk(1, 40, 30);
    tk(1, 40, 30);
    step(1, 1, 40, 30);
    st_cur = 0;
    tk(0, 0, 0);
    st_cur = 1;
    tk(0, 0, 0);

    tk(1, 40, 30);
    tk(0, 0, 0);
    tk(0, 0, 0);
    reset_now();
    step(0, 0, 0, 0);
    rst_hold = 1'b0;
    step(0, 0, 0, 0);

    repeat (3000) begin
      r = $urandom_range(0, 99);
      st_cur = (r < 1) ? $urandom_range(0, 5) : 1;
      rst_hold = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 9) == 0) begin
        lx_cur = $urandom_range(0, 127);
        ly_cur = $urandom_range(0, 127);
      end
      dx = $urandom_range(0, 8);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           lx_cur + dx - 4, ly_cur + $urandom_range(0, 8) - 4);
    end

    rst_hold = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    @(posedge clk);
    #2;
    cmp("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hit_responder.md
HIT_RESPONDER -- requirements
Module: hit_responder

Interface
REQ-001 SHALL have parameter DAMAGE, default 10, meaning HP removed per accepted hit.
REQ-002 SHALL have parameter INVULN_TICKS, default 16, meaning ticks of invulnerability after an accepted hit.
REQ-003 SHALL have parameter HP_MAX, default 100, meaning HP loaded on reset and outside GAME.
REQ-004 SHALL have port clk  input  1  system clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port tick  input  1  one-cycle frame-step enable; all game updates occur only on tick cycles.
REQ-007 SHALL have port state  input  3  game state: MENU=0, GAME=1, P1WIN=2, P2WIN=3, TIE=4, PIONT=5.
REQ-008 SHALL have port arm_active  input  1  attacker projectile is in flight (ATTACK_DOWN phase).
REQ-009 SHALL have ports arm_x, arm_y  input  7 each  projectile position, units of 10 px.
REQ-010 SHALL have ports loc_x, loc_y  input  7 each  defender position, units of 10 px.
REQ-011 SHALL have port hp  output  8  defender HP.
REQ-012 SHALL have port hit_ack  output  1  one-cycle pulse to attacker: hit accepted, retract projectile.
REQ-013 SHALL have port flash  output  1  sprite blink enable for renderer.
REQ-014 SHALL have port ko  output  1  HP exhausted.
REQ-015 SHALL have port knock  output  1  push-back request to movement block.

Function
REQ-016 SHALL implement states IDLE, ALIVE, INVULN, KO.
REQ-017 SHALL go to IDLE, with hp=HP_MAX, in the clock cycle after any tick where state!=GAME, from any state.
REQ-018 SHALL go IDLE->ALIVE on a tick with state==GAME.
REQ-019 SHALL define collision as all of: 10*arm_y >= 10*loc_y-20; 10*arm_y <= 10*loc_y+30; 10*arm_x >= 10*loc_x-20; 10*arm_x <= 10*loc_x+29.
REQ-020 SHALL evaluate collision using compares at least 11 bits wide, signed or offset so that loc-20 cannot wrap.
REQ-021 SHALL accept a hit only in ALIVE, on a tick, with arm_active=1 and collision true.
REQ-022 SHALL, on an accepted hit at tick cycle N, in cycle N+1: set hp=max(hp-DAMAGE,0), pulse hit_ack high for exactly one clk, and enter INVULN with counter=INVULN_TICKS.
REQ-023 SHALL saturate hp at 0 and never underflow it.
REQ-024 SHALL enter KO instead of INVULN when the post-hit hp is 0.
REQ-025 SHALL not accept a hit and not pulse hit_ack while in INVULN; the projectile passes through.
REQ-026 SHALL decrement the INVULN counter on each tick and return to ALIVE on the tick where it reaches 0.
REQ-027 SHALL drive flash as bit 1 of the INVULN counter while in INVULN, and 0 otherwise.
REQ-028 SHALL hold ko=1 in KO until state!=GAME, with hp frozen in KO.
REQ-029 SHALL take no action on a non-tick cycle except clearing hit_ack.

Reset
REQ-030 SHALL, on rst, set state=IDLE, hp=HP_MAX, hit_ack=0, flash=0, ko=0, knock=0, and INVULN counter=0.
REQ-031 SHALL apply reset immediately when rst is asserted mid-INVULN or mid-knock, without waiting for tick.

Configuration
REQ-032 SHALL, with HIT_KNOCKBACK_EN defined, assert knock for 4 ticks starting in cycle N+1 of an accepted hit that does not cause KO.
REQ-033 SHALL, without HIT_KNOCKBACK_EN, tie knock to 0 and omit its counter, keeping the port.

Structure
REQ-034 SHALL take the state encodings, geometry constants (arms_side=20, ch_wide=30, ch_height=50) and HP_MAX/DAMAGE defaults from the shared package game_pkg.
REQ-035 SHALL place the collision test in a combinational sub-module hit_box_cmp, reused by the P1 side.

Verification
REQ-036 SHALL test: rst, then state=GAME with a tick -> ALIVE, hp=100, ko=0.
REQ-037 SHALL test: loc=(40,30), arm=(39,30), arm_active=1, tick -> next cycle hp=90, hit_ack high for 1 cycle, flash toggles every 2 ticks.
REQ-038 SHALL test: same overlap held for 16 ticks -> no further damage; on tick 17 -> hp=80.
REQ-039 SHALL test: boundary arm_x=loc_x+3 (10*arm_x=loc+30 > loc+29) -> no hit; arm_x=loc_x-2 -> hit.
REQ-040 SHALL test: 10 accepted hits -> hp=0, ko=1, 11th overlap gives no hit_ack and hp stays 0; state=MENU plus tick -> hp=100, ko=0.
REQ-041 SHALL test: rst asserted mid-INVULN -> all outputs at reset values immediately; with HIT_KNOCKBACK_EN, knock high for exactly 4 ticks after a hit.
